// File: rtl/dm_access.sv
// MEM-stage data memory with byte/half/word access: stores commit on the edge, loads return 1 cycle later.
// No backpressure; every request is taken on its edge. DM_ALIGN_CHECK_EN: misaligned accesses are suppressed and flagged.
module dm_access #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  input  logic        load_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        misalign,
  output logic [31:0] misalign_addr
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]   dmem [0:DEPTH_WORDS-1];
  logic [AW-1:0] idx;
  logic [1:0]    off;
  logic [3:0]    be;
  logic [31:0]   wlane;
  logic [31:0]   word;
  logic [15:0]   half;
  logic [7:0]    byte_sel;
  logic [31:0]   ext;
  logic          ok;
  logic          do_store;
  logic          do_load;
  logic          unused_addr;

  // Upper address bits alias onto the same word.
  assign idx         = addr[AW+1:2];
  assign unused_addr = ^addr[31:AW+2];

  // Lane offset is forced to the access alignment; a misaligned access never reaches here when checking is on.
  always_comb begin
    off   = 2'b00;
    be    = 4'hF;
    wlane = wdata;
    case (size)
      2'b01: begin
        off   = {addr[1], 1'b0};
        be    = addr[1] ? 4'hC : 4'h3;
        wlane = {wdata[15:0], wdata[15:0]};
      end
      2'b10: begin
        off   = addr[1:0];
        be    = 4'b0001 << addr[1:0];
        wlane = {4{wdata[7:0]}};
      end
      default: begin
        off   = 2'b00;
        be    = 4'hF;
        wlane = wdata;
      end
    endcase
  end

`ifdef DM_ALIGN_CHECK_EN
  logic mis;
  always_comb begin
    mis = 1'b0;
    case (size)
      2'b01:   mis = addr[0];
      2'b10:   mis = 1'b0;
      default: mis = (addr[1:0] != 2'b00);
    endcase
  end
  assign ok = !mis;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      misalign      <= 1'b0;
      misalign_addr <= 32'h0;
    end else if ((mem_read || mem_write) && mis) begin
      misalign <= 1'b1;
      if (!misalign)
        misalign_addr <= addr;
    end
  end
`else
  assign ok            = 1'b1;
  assign misalign      = 1'b0;
  assign misalign_addr = 32'h0;
`endif

  assign do_store = mem_write && ok;
  assign do_load  = mem_read && !mem_write && ok;

  // Storage is deliberately outside the reset domain; a store seen while rst is low is dropped.
  always_ff @(posedge clk) begin
    if (rst && do_store) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i])
          dmem[idx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

  always_comb begin
    word     = dmem[idx];
    half     = off[1] ? word[31:16] : word[15:0];
    byte_sel = word[8*off +: 8];
    case (size)
      2'b01:   ext = load_unsigned ? {16'h0, half} : {{16{half[15]}}, half};
      2'b10:   ext = load_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      default: ext = word;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata       <= 32'h0;
      rdata_valid <= 1'b0;
    end else begin
      rdata_valid <= do_load;
      if (do_load)
        rdata <= ext;
    end
  end

endmodule
